// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and defaults.
// HALT exists only with PC_UNIT_MISALIGN_TRAP_EN.
package rv32i_pkg;

   localparam int          XLEN_D    = 32;
   localparam int          PC_INCR_D = 4;
   localparam logic [31:0] PC_INIT_D = 32'h0;

   typedef enum logic [2:0] {
      RESET,
      ISSUE,
      WAIT,
      HOLD
`ifdef PC_UNIT_MISALIGN_TRAP_EN
      , HALT
`endif
   } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Handshake bundle between pc_unit, decode and fetch.
// master = pc_unit side, slave = environment side.
interface pc_unit_if
   import rv32i_pkg::*;
#(
   parameter int XLEN = XLEN_D
);

   logic            i_stall;
   logic            i_redirect_valid;
   logic [XLEN-1:0] i_redirect_pc;
   logic            i_fetch_valid;
   logic            o_fetch_instr;
   logic [XLEN-1:0] o_pc;
   logic            o_instr_valid;
   logic [XLEN-1:0] o_instr_pc;
   logic            o_misaligned;
   logic [XLEN-1:0] o_exc_pc;

   modport master (
      input  i_stall,
      input  i_redirect_valid,
      input  i_redirect_pc,
      input  i_fetch_valid,
      output o_fetch_instr,
      output o_pc,
      output o_instr_valid,
      output o_instr_pc,
      output o_misaligned,
      output o_exc_pc
   );

   modport slave (
      output i_stall,
      output i_redirect_valid,
      output i_redirect_pc,
      output i_fetch_valid,
      input  o_fetch_instr,
      input  o_pc,
      input  o_instr_valid,
      input  o_instr_pc,
      input  o_misaligned,
      input  o_exc_pc
   );

endinterface

// File: rtl/pc_align_chk.sv
// Redirect target alignment check (PC_UNIT_MISALIGN_TRAP_EN)
// or low-bit masking when the trap is compiled out.
module pc_align_chk
   import rv32i_pkg::*;
#(
   parameter int XLEN = XLEN_D
) (
   input  logic [XLEN-1:0] target,
`ifdef PC_UNIT_MISALIGN_TRAP_EN
   output logic            misaligned,
`endif
   output logic [XLEN-1:0] target_ok
);

`ifdef PC_UNIT_MISALIGN_TRAP_EN
   assign misaligned = |target[1:0];
   assign target_ok  = target;
`else
   assign target_ok  = target & ~XLEN'(3);
`endif

endmodule

// File: rtl/pc_unit.sv
// PC sequencer: issue, wait, advance/redirect, tag response.
// PC_UNIT_MISALIGN_TRAP_EN adds the misaligned-redirect trap.
module pc_unit
   import rv32i_pkg::*;
#(
   parameter int              XLEN    = XLEN_D,
   parameter int              PC_INCR = PC_INCR_D,
   parameter logic [XLEN-1:0] PC_INIT = XLEN'(PC_INIT_D)
) (
   input logic       clk,
   input logic       rstn,
   pc_unit_if.master bus
);

   pc_state_e       state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] inflight_pc, inflight_n;
   logic            kill, kill_n;
   logic            pend, pend_n;
   logic [XLEN-1:0] tgt, tgt_n;
   logic            ivalid, ivalid_n;
   logic [XLEN-1:0] ipc, ipc_n;
   logic [XLEN-1:0] target;
   logic            redir;

   assign redir = bus.i_redirect_valid;

`ifdef PC_UNIT_MISALIGN_TRAP_EN
   logic            mis, mis_n, tgt_mis;
   logic [XLEN-1:0] exc, exc_n;

   pc_align_chk #(.XLEN(XLEN)) u_align (
      .target     (bus.i_redirect_pc),
      .misaligned (tgt_mis),
      .target_ok  (target)
   );
`else
   pc_align_chk #(.XLEN(XLEN)) u_align (
      .target    (bus.i_redirect_pc),
      .target_ok (target)
   );
`endif

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      inflight_n = inflight_pc;
      kill_n     = kill;
      pend_n     = pend;
      tgt_n      = tgt;
      ivalid_n   = 1'b0;
      ipc_n      = ipc;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
      mis_n      = 1'b0;
      exc_n      = exc;
`endif
      unique case (state)
         RESET: state_n = ISSUE;
         ISSUE: begin
            inflight_n = pc;
            state_n    = WAIT;
            if (redir) begin
               kill_n = 1'b1;
               pend_n = 1'b1;
               tgt_n  = target;
            end
         end
         WAIT: begin
            if (bus.i_fetch_valid) begin
               ivalid_n = !(kill || redir);
               ipc_n    = inflight_pc;
               // newest redirect wins over a pending one
               if (redir)     pc_n = target;
               else if (pend) pc_n = tgt;
               else           pc_n = pc + XLEN'(PC_INCR);
               kill_n  = 1'b0;
               pend_n  = 1'b0;
               state_n = bus.i_stall ? HOLD : ISSUE;
            end else if (redir) begin
               kill_n = 1'b1;
               pend_n = 1'b1;
               tgt_n  = target;
            end
         end
         HOLD: begin
            if (redir) pc_n = target;
            if (!bus.i_stall) state_n = ISSUE;
         end
`ifdef PC_UNIT_MISALIGN_TRAP_EN
         HALT: begin
            if (redir) begin
               pc_n    = target;
               state_n = ISSUE;
            end
         end
`endif
         default: state_n = RESET;
      endcase
`ifdef PC_UNIT_MISALIGN_TRAP_EN
      // trap overrides every other redirect effect
      if (redir && tgt_mis && state != RESET) begin
         state_n  = HALT;
         pc_n     = pc;
         kill_n   = 1'b0;
         pend_n   = 1'b0;
         ivalid_n = 1'b0;
         mis_n    = 1'b1;
         exc_n    = bus.i_redirect_pc;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= RESET;
         pc          <= PC_INIT;
         inflight_pc <= '0;
         kill        <= 1'b0;
         pend        <= 1'b0;
         tgt         <= '0;
         ivalid      <= 1'b0;
         ipc         <= '0;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
         mis         <= 1'b0;
         exc         <= '0;
`endif
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         inflight_pc <= inflight_n;
         kill        <= kill_n;
         pend        <= pend_n;
         tgt         <= tgt_n;
         ivalid      <= ivalid_n;
         ipc         <= ipc_n;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
         mis         <= mis_n;
         exc         <= exc_n;
`endif
      end
   end

   assign bus.o_fetch_instr = (state == ISSUE);
   assign bus.o_pc          = pc;
   assign bus.o_instr_valid = ivalid;
   assign bus.o_instr_pc    = ipc;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
   assign bus.o_misaligned  = mis;
   assign bus.o_exc_pc      = exc;
`else
   assign bus.o_misaligned  = 1'b0;
   assign bus.o_exc_pc      = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit, transaction-level model.
// Honours PC_UNIT_MISALIGN_TRAP_EN for the trap scenario.
module tb_pc_unit;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   pc_unit_if #(.XLEN(32)) bus ();

   pc_unit #(
      .XLEN    (32),
      .PC_INCR (4),
      .PC_INIT (32'h100)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] tmask(input logic [31:0] t);
`ifdef PC_UNIT_MISALIGN_TRAP_EN
      return t;
`else
      return t & ~32'd3;
`endif
   endfunction

   function automatic logic [31:0] rand_tgt();
      logic [31:0] t;
      t = $urandom;
`ifdef PC_UNIT_MISALIGN_TRAP_EN
      t = t & ~32'd3;
`endif
      return t;
   endfunction

   task automatic idle_inputs();
      bus.i_stall          = 1'b0;
      bus.i_redirect_valid = 1'b0;
      bus.i_redirect_pc    = '0;
      bus.i_fetch_valid    = 1'b0;
   endtask

   // One fetch from its ISSUE cycle to the next ISSUE cycle.
   // r1/r2: redirect cycle offsets (0 = issue, lat = response).
   // stall_n: stall cycles starting at response; hold_r: HOLD redirect.
   task automatic txn(input int lat,
                      input int r1, input logic [31:0] t1,
                      input int r2, input logic [31:0] t2,
                      input int stall_n,
                      input int hold_r, input logic [31:0] th);
      logic [31:0] cur, nxt;
      bit          killed;
      int          n;
      cur    = exp_pc;
      nxt    = cur + 32'd4;
      killed = 1'b0;
      checks++;
      if (bus.o_fetch_instr !== 1'b1) begin
         errors++;
         $display("FAIL issue_time fetch_instr=%b want 1 pc=%h",
                  bus.o_fetch_instr, cur);
         n = 0;
         while (bus.o_fetch_instr !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
         end
      end
      checks++;
      if (bus.o_pc !== cur) begin
         errors++;
         $display("FAIL issue_pc got %h want %h", bus.o_pc, cur);
      end
      for (int c = 0; c <= lat; c++) begin
         if (c > 0) begin
            @(negedge clk);
            checks++;
            if (bus.o_fetch_instr !== 1'b0 || bus.o_pc !== cur ||
                bus.o_instr_valid !== 1'b0) begin
               errors++;
               $display("FAIL wait_hold req=%b pc=%h vld=%b want 0 %h 0",
                        bus.o_fetch_instr, bus.o_pc,
                        bus.o_instr_valid, cur);
            end
         end
         bus.i_redirect_valid = (c == r1) || (c == r2);
         bus.i_redirect_pc    = (c == r2) ? t2 : t1;
         if (c == r1 || c == r2) begin
            killed = 1'b1;
            nxt    = tmask((c == r2) ? t2 : t1);
         end
         bus.i_fetch_valid = (c == lat);
         bus.i_stall = (c == lat) ? (stall_n > 0)
                                  : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      checks++;
      if (bus.o_instr_valid !== !killed) begin
         errors++;
         $display("FAIL instr_valid got %b want %b pc=%h",
                  bus.o_instr_valid, !killed, cur);
      end
      checks++;
      if (bus.o_instr_pc !== cur) begin
         errors++;
         $display("FAIL instr_pc got %h want %h", bus.o_instr_pc, cur);
      end
      checks++;
      if (bus.o_misaligned !== 1'b0) begin
         errors++;
         $display("FAIL no_trap misaligned got %b want 0",
                  bus.o_misaligned);
      end
      for (int k = 1; k <= stall_n; k++) begin
         if (k > 1) @(negedge clk);
         checks++;
         if (bus.o_fetch_instr !== 1'b0) begin
            errors++;
            $display("FAIL stall_block fetch_instr got 1 want 0 k=%0d", k);
         end
         if (k > 1) begin
            checks++;
            if (bus.o_instr_valid !== 1'b0) begin
               errors++;
               $display("FAIL valid_pulse got 1 want 0 k=%0d", k);
            end
         end
         bus.i_fetch_valid    = 1'b0;
         bus.i_stall          = (k < stall_n);
         bus.i_redirect_valid = (k == hold_r);
         bus.i_redirect_pc    = th;
         if (k == hold_r) nxt = tmask(th);
      end
      if (stall_n > 0) @(negedge clk);
      idle_inputs();
      exp_pc = nxt;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.o_fetch_instr !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctl req=%b vld=%b want 0 0",
                  bus.o_fetch_instr, bus.o_instr_valid);
      end
      checks++;
      if (bus.o_pc !== 32'h100) begin
         errors++;
         $display("FAIL rst_pc got %h want 00000100", bus.o_pc);
      end
      checks++;
      if (bus.o_instr_pc !== 32'h0 || bus.o_misaligned !== 1'b0 ||
          bus.o_exc_pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_out ipc=%h mis=%b exc=%h want 0 0 0",
                  bus.o_instr_pc, bus.o_misaligned, bus.o_exc_pc);
      end
      rstn = 1'b1;
      checks++;
      if (bus.o_fetch_instr !== 1'b0) begin
         errors++;
         $display("FAIL rst_idle fetch_instr got 1 want 0");
      end
      @(negedge clk);
      exp_pc = 32'h100;
   endtask

   task automatic test_sequential();
      repeat (3) txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_stall();
      txn(2, -1, 0, -1, 0, 5, 0, 0);
      txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_redirect_wait();
      txn(2, 1, 32'h200, -1, 0, 0, 0, 0);
      txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_redirect_coincident();
      txn(2, 2, 32'h200, -1, 0, 0, 0, 0);
      txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_redirect_hold();
      txn(2, -1, 0, -1, 0, 3, 2, 32'h200);
      txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_overwrite();
      txn(3, 0, 32'h400, 2, 32'h500, 0, 0, 0);
      txn(1, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_misalign();
      txn(2, 1, 32'h200, -1, 0, 0, 0, 0);
`ifdef PC_UNIT_MISALIGN_TRAP_EN
      @(negedge clk);
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc    = 32'h202;
      @(negedge clk);
      idle_inputs();
      bus.i_fetch_valid = 1'b1;
      checks++;
      if (bus.o_misaligned !== 1'b1 || bus.o_exc_pc !== 32'h202) begin
         errors++;
         $display("FAIL trap got mis=%b exc=%h want 1 00000202",
                  bus.o_misaligned, bus.o_exc_pc);
      end
      @(negedge clk);
      bus.i_fetch_valid = 1'b0;
      checks++;
      if (bus.o_misaligned !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL trap_pulse mis=%b vld=%b want 0 0",
                  bus.o_misaligned, bus.o_instr_valid);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.o_fetch_instr !== 1'b0) begin
            errors++;
            $display("FAIL halt_req got 1 want 0 i=%0d", i);
         end
         @(negedge clk);
      end
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc    = 32'h300;
      @(negedge clk);
      exp_pc = 32'h300;
      txn(2, -1, 0, -1, 0, 0, 0, 0);
`else
      txn(2, 1, 32'h202, -1, 0, 0, 0, 0);
      checks++;
      if (exp_pc !== 32'h200 || bus.o_pc !== 32'h200 ||
          bus.o_exc_pc !== 32'h0) begin
         errors++;
         $display("FAIL mask pc=%h exc=%h want 00000200 0",
                  bus.o_pc, bus.o_exc_pc);
      end
      txn(2, -1, 0, -1, 0, 0, 0, 0);
`endif
   endtask

   task automatic test_wrap();
      txn(2, 1, 32'hFFFF_FFFC, -1, 0, 0, 0, 0);
      txn(2, -1, 0, -1, 0, 0, 0, 0);
      txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_fetch_instr !== 1'b0 || bus.o_pc !== 32'h100) begin
         errors++;
         $display("FAIL midrst req=%b pc=%h want 0 00000100",
                  bus.o_fetch_instr, bus.o_pc);
      end
      rstn = 1'b1;
      bus.i_fetch_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.o_fetch_instr !== 1'b1 || bus.o_pc !== 32'h100 ||
          bus.o_instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_issue req=%b pc=%h vld=%b want 1 100 0",
                  bus.o_fetch_instr, bus.o_pc, bus.o_instr_valid);
      end
      @(negedge clk);
      bus.i_fetch_valid = 1'b0;
      checks++;
      if (bus.o_instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL stale_resp vld got 1 want 0");
      end
      @(negedge clk);
      bus.i_fetch_valid = 1'b1;
      @(negedge clk);
      bus.i_fetch_valid = 1'b0;
      checks++;
      if (bus.o_instr_valid !== 1'b1 || bus.o_instr_pc !== 32'h100 ||
          bus.o_pc !== 32'h104) begin
         errors++;
         $display("FAIL midrst_resume vld=%b ipc=%h pc=%h want 1 100 104",
                  bus.o_instr_valid, bus.o_instr_pc, bus.o_pc);
      end
      exp_pc = 32'h104;
      txn(2, -1, 0, -1, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      int lat, r1, r2, st, hr;
      for (int i = 0; i < 60; i++) begin
         lat = $urandom_range(1, 4);
         r1  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lat) : -1;
         r2  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
         if (r2 == r1) r2 = -1;
         st  = $urandom_range(0, 3);
         hr  = (st > 0 && $urandom_range(0, 1) == 1)
                  ? $urandom_range(1, st) : 0;
         txn(lat, r1, rand_tgt(), r2, rand_tgt(), st, hr, rand_tgt());
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_coincident();
      test_redirect_hold();
      test_overwrite();
      test_misalign();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
